// File: rtl/muldiv_pkg.sv
// Shared op codes, controller state encoding and op classification helpers
// for the EX-stage multiply/divide issue controller.
package muldiv_pkg;

    localparam logic [3:0] MD_OP_NONE  = 4'b0000;
    localparam logic [3:0] MD_OP_DIV   = 4'b0001;
    localparam logic [3:0] MD_OP_DIVU  = 4'b0010;
    localparam logic [3:0] MD_OP_MFHI  = 4'b0011;
    localparam logic [3:0] MD_OP_MFLO  = 4'b0100;
    localparam logic [3:0] MD_OP_MTHI  = 4'b0101;
    localparam logic [3:0] MD_OP_MTLO  = 4'b0110;
    localparam logic [3:0] MD_OP_MUL   = 4'b0111;
    localparam logic [3:0] MD_OP_MULT  = 4'b1000;
    localparam logic [3:0] MD_OP_MULTU = 4'b1001;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_ISSUE = 2'd1,
        MD_WAIT  = 2'd2,
        MD_DONE  = 2'd3
    } md_state_t;

    // Ops whose unit result is returned to the pipeline; all others answer 0.
    function automatic logic md_op_has_result(input logic [3:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_MFHI) || (op == MD_OP_MFLO);
    endfunction

    function automatic logic md_op_legal(input logic [3:0] op);
        return (op >= MD_OP_DIV) && (op <= MD_OP_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Issue/sequencing controller between EX and the multiply/divide unit.
// Optional perf counters are built when MULDIV_CTRL_PERF_EN is defined.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    // Handshakes: a transfer happens on a posedge where valid && ready;
    // valid never waits on ready, and the payload is stable while valid is high.
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    output logic        req_ready,
    input  logic        flush,
    output logic [3:0]  md_op,
    output logic [31:0] md_rs,
    output logic [31:0] md_rt,
    input  logic        md_stall,
    input  logic [31:0] md_res,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
`ifdef MULDIV_CTRL_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall_cycles
`endif
);

    md_state_t        state_q, state_d;
    logic [3:0]       op_q;
    logic [31:0]      rs_q, rt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rdata_q;
    logic             rerr_q;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything, including a new request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (!flush && req_valid) begin
                    state_d = md_op_legal(req_op) ? MD_ISSUE : MD_DONE;
                end
            end
            MD_ISSUE: begin
                state_d = flush ? MD_IDLE : MD_WAIT;
            end
            MD_WAIT: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else if (!md_stall || timeout_hit) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                if (flush || resp_ready) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Operand latch, WAIT counter and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MD_OP_NONE;
            rs_q    <= '0;
            rt_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (!flush && req_valid) begin
                        op_q    <= req_op;
                        rs_q    <= req_rs;
                        rt_q    <= req_rt;
                        rdata_q <= '0;
                        rerr_q  <= !md_op_legal(req_op);
                    end
                end
                MD_ISSUE: begin
                    cnt_q <= '0;
                end
                MD_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (!md_stall) begin
                        rdata_q <= md_op_has_result(op_q) ? md_res : 32'd0;
                        rerr_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        rerr_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs; the unit sees NONE outside ISSUE/WAIT so its done flags clear.
    always_comb begin
        req_ready  = 1'b0;
        md_op      = MD_OP_NONE;
        md_rs      = '0;
        md_rt      = '0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        busy       = (state_q != MD_IDLE);
        dbg_state  = state_q;
        case (state_q)
            MD_IDLE: begin
                req_ready = 1'b1;
            end
            MD_ISSUE, MD_WAIT: begin
                md_op = op_q;
                md_rs = rs_q;
                md_rt = rt_q;
            end
            MD_DONE: begin
                resp_valid = 1'b1;
                resp_data  = rdata_q;
                resp_err   = rerr_q;
            end
            default: begin
            end
        endcase
    end

`ifdef MULDIV_CTRL_PERF_EN
    // A flushed DONE is a dropped response, not a completed one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops          <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state_q == MD_DONE && resp_ready && !flush && !rerr_q) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (state_q == MD_WAIT && md_stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural HI/LO unit on negedge
// and a response scoreboard fed by the stimulus process.
module tb_muldiv_ctrl;

    localparam int TIMEOUT_CYCLES = 64;
    localparam logic [3:0] OP_DIV = 4'd1, OP_DIVU = 4'd2, OP_MFHI = 4'd3, OP_MFLO = 4'd4;
    localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MUL = 4'd7, OP_MULT = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, flush;
    logic [3:0]  req_op, md_op;
    logic [31:0] req_rs, req_rt, md_rs, md_rt;
    logic        md_stall = 1'b0;
    logic [31:0] md_res = 32'd0;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_data;
    logic [1:0]  dbg_state;
`ifdef MULDIV_CTRL_PERF_EN
    logic [31:0] perf_ops, perf_stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    muldiv_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .req_ready(req_ready), .flush(flush),
        .md_op(md_op), .md_rs(md_rs), .md_rt(md_rt), .md_stall(md_stall), .md_res(md_res),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .dbg_state(dbg_state)
`ifdef MULDIV_CTRL_PERF_EN
        , .perf_ops(perf_ops), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural unit ----------------
    logic        hang = 1'b0;
    logic        u_active = 1'b0, u_done = 1'b0;
    int          u_cnt = 0;
    logic [31:0] u_hi = 32'd0, u_lo = 32'd0;
    logic signed [63:0] u_sprod;
    logic [63:0] u_uprod;

    always @(negedge clk) begin
        if (md_op == 4'd0) begin
            u_active = 1'b0;
            u_done   = 1'b0;
            md_stall = 1'b0;
        end else if (hang) begin
            md_stall = 1'b1;
        end else if (!u_done) begin
            if (!u_active) begin
                u_active = 1'b1;
                u_cnt = (md_op == OP_DIV || md_op == OP_DIVU) ? 33 :
                        (md_op == OP_MUL || md_op == OP_MULT || md_op == OP_MULTU) ? 4 : 0;
            end
            if (u_cnt == 0) begin
                u_sprod = $signed(md_rs) * $signed(md_rt);
                u_uprod = {32'd0, md_rs} * {32'd0, md_rt};
                case (md_op)
                    OP_DIV:   begin u_lo = $signed(md_rs) / $signed(md_rt); u_hi = $signed(md_rs) % $signed(md_rt); end
                    OP_DIVU:  begin u_lo = md_rs / md_rt; u_hi = md_rs % md_rt; end
                    OP_MFHI:  md_res = u_hi;
                    OP_MFLO:  md_res = u_lo;
                    OP_MTHI:  u_hi = md_rs;
                    OP_MTLO:  u_lo = md_rs;
                    OP_MUL:   md_res = u_sprod[31:0];
                    OP_MULT:  {u_hi, u_lo} = u_sprod;
                    OP_MULTU: {u_hi, u_lo} = u_uprod;
                    default: ;
                endcase
                u_done   = 1'b1;
                md_stall = 1'b0;
            end else begin
                u_cnt    = u_cnt - 1;
                md_stall = 1'b1;
            end
        end
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%09h expected 0x%09h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic err, input logic [31:0] data);
        exp_q.push_back({err, data});
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int n = 0;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        check("issue_ready", {32'd0, req_ready}, 33'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 200) begin
            step();
            n++;
        end
        if (!resp_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_wait_timeout: got resp_valid=0 required 1 at %0t", $time);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check("drain_idle", {31'd0, busy, exp_q.size() != 0}, 33'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"}, {32'd0, req_ready}, 33'd1);
        check({name, "_resp"}, {resp_valid, resp_err, busy, md_op, dbg_state}, 33'd0);
        check({name, "_md_rs"}, {1'b0, md_rs}, 33'd0);
        check({name, "_md_rt"}, {1'b0, md_rt}, 33'd0);
        check({name, "_resp_data"}, {1'b0, resp_data}, 33'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic        hold_seen = 1'b0;
    logic [32:0] hold_val;
    logic [32:0] exp_v;

    always @(negedge clk) begin
        if (rst || !resp_valid) begin
            hold_seen = 1'b0;
        end else begin
            if (hold_seen) check("resp_hold", {resp_err, resp_data}, hold_val);
            if (resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_unexpected: got 0x%09h required no response", {resp_err, resp_data});
                end else begin
                    exp_v = exp_q.pop_front();
                    check("resp", {resp_err, resp_data}, exp_v);
                end
                hold_seen = 1'b0;
            end else begin
                hold_seen = 1'b1;
                hold_val  = {resp_err, resp_data};
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int  n;
        logic busy_ok;
        rst = 1'b1;
        req_valid = 1'b0; req_op = 4'd0; req_rs = 32'd0; req_rt = 32'd0;
        flush = 1'b0; resp_ready = 1'b1;
        repeat (2) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // MULTU then read back LO/HI
        expect_resp(1'b0, 32'd0);  issue(OP_MULTU, 32'd3, 32'd5); wait_idle();
        expect_resp(1'b0, 32'hF);  issue(OP_MFLO, 32'd0, 32'd0);  wait_idle();
        expect_resp(1'b0, 32'd0);  issue(OP_MFHI, 32'd0, 32'd0);  wait_idle();

        // MUL low word, unit released while response is presented
        expect_resp(1'b0, 32'hFFFF_FFFA);
        issue(OP_MUL, 32'hFFFF_FFFE, 32'd3);
        wait_resp(n);
        check("mul_md_op_done", {29'd0, md_op}, 33'd0);
        wait_idle();

        // DIV latency and busy
        expect_resp(1'b0, 32'd0);
        issue(OP_DIV, 32'd7, 32'd2);
        n = 0;
        busy_ok = 1'b1;
        while (!resp_valid && n < 60) begin
            busy_ok &= busy;
            step();
            n++;
        end
        check("div_busy", {32'd0, busy_ok & busy}, 33'd1);
        check("div_latency_le36", {32'd0, (n <= 36 && resp_valid)}, 33'd1);
        wait_idle();
        expect_resp(1'b0, 32'd3);  issue(OP_MFLO, 32'd0, 32'd0);  wait_idle();
        expect_resp(1'b0, 32'd1);  issue(OP_MFHI, 32'd0, 32'd0);  wait_idle();

        // Flush at WAIT cycle 10: no response, unit aborts, HI/LO untouched
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (10) step();
        check("flush_in_wait", {31'd0, dbg_state}, 33'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_md_op", {29'd0, md_op}, 33'd0);
        check("flush_idle", {30'd0, resp_valid, busy, req_ready}, 33'd1);
        step();
        check("flush_no_resp", {30'd0, resp_valid, busy, req_ready}, 33'd1);

        // Flush wins over a request in IDLE
        req_valid = 1'b1; req_op = OP_MTLO; req_rs = 32'h55; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_wins", {32'd0, busy}, 33'd0);
        expect_resp(1'b0, 32'd3);  issue(OP_MFLO, 32'd0, 32'd0);  wait_idle();

        // resp_ready with req_valid in DONE: only the response completes
        resp_ready = 1'b0;
        expect_resp(1'b0, 32'd3);
        issue(OP_MFLO, 32'd0, 32'd0);
        wait_resp(n);
        step();
        step();
        req_valid = 1'b1; req_op = OP_MTHI; req_rs = 32'h77; req_rt = 32'd0;
        resp_ready = 1'b1;
        step();
        check("done_then_idle", {31'd0, dbg_state}, 33'd0);
        step();
        req_valid = 1'b0;
        check("req_after_done", {31'd0, dbg_state}, 33'd1);
        expect_resp(1'b0, 32'd0);
        wait_idle();
        expect_resp(1'b0, 32'h77); issue(OP_MFHI, 32'd0, 32'd0);  wait_idle();

        // Hung unit: timeout after TIMEOUT_CYCLES in WAIT, response held
        hang = 1'b1;
        resp_ready = 1'b0;
        expect_resp(1'b1, 32'd0);
        issue(OP_MULT, 32'd2, 32'd3);
        wait_resp(n);
        check("timeout_cycles", n, TIMEOUT_CYCLES + 1);
        repeat (3) step();
        resp_ready = 1'b1;
        wait_idle();
        hang = 1'b0;

        // Illegal op codes answered straight away with an error
        expect_resp(1'b1, 32'd0);
        issue(4'hC, 32'd1, 32'd1);
        check("illegal_c_done", {31'd0, dbg_state}, 33'd3);
        wait_idle();
        expect_resp(1'b1, 32'd0);
        issue(4'h0, 32'd1, 32'd1);
        check("illegal_0_done", {31'd0, dbg_state}, 33'd3);
        wait_idle();

        // Reset in the middle of a DIVU
        issue(OP_DIVU, 32'd50, 32'd3);
        repeat (10) step();
        rst = 1'b1;
        #1;
        check_reset_outputs("midop_reset");
        step();
        rst = 1'b0;
        step();
        expect_resp(1'b0, 32'd0);      issue(OP_MTLO, 32'h1234, 32'd0); wait_idle();
        expect_resp(1'b0, 32'h1234);   issue(OP_MFLO, 32'd0, 32'd0);    wait_idle();

        check("exp_q_empty", exp_q.size(), 33'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
